ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 64x32 dual-port RAM between two req/ack requesters.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).

module ram_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt_id,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb
);

    localparam logic       S_IDLE   = 1'b0;
    localparam logic       S_BUSY   = 1'b1;
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    logic              r_state;
    logic [1:0]        r_lat_cnt;
    logic              r_we_txn;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata;
    logic              r_busy;
    logic              r_gnt_id;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_dina;
    logic [ADDR_W-1:0] r_addrb;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_any;
    logic              w_win;
    logic              w_issue;
    logic              w_done;
    logic              w_we_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;

    // A requester acked on the previous edge is masked for one cycle.
    assign w_elig0 = req0 & ~r_ack0;
    assign w_elig1 = req1 & ~r_ack1;
    assign w_any   = w_elig0 | w_elig1;

`ifdef ARB_FIXED_PRIO_EN
    // Requester 1 only wins when requester 0 is not eligible.
    assign w_win = ~w_elig0 & w_elig1;
`else
    logic r_rr_ptr;

    // On a tie the round-robin pointer decides; a lone requester always wins.
    assign w_win = (w_elig0 & w_elig1) ? r_rr_ptr : w_elig1;

    // After each grant, priority passes to the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_issue) begin
            r_rr_ptr <= ~w_win;
        end
    end
`endif

    assign w_issue     = (r_state == S_IDLE) & w_any;
    assign w_done      = (r_state == S_BUSY) & (r_lat_cnt == 2'd0);
    assign w_we_sel    = w_win ? we1    : we0;
    assign w_addr_sel  = w_win ? addr1  : addr0;
    assign w_wdata_sel = w_win ? wdata1 : wdata0;

    // Transaction control: issue from IDLE, count read latency in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 2'd0;
            r_busy    <= 1'b0;
            r_gnt_id  <= 1'b0;
            r_we_txn  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state   <= S_BUSY;
                        r_lat_cnt <= LAT_INIT;
                        r_busy    <= 1'b1;
                        r_gnt_id  <= w_win;
                        r_we_txn  <= w_we_sel;
                    end
                end
                S_BUSY: begin
                    if (r_lat_cnt != 2'd0) begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM port drive: addresses and data hold, write enable pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_addrb <= '0;
            r_dina  <= '0;
        end else begin
            r_wea <= w_issue ? w_we_sel : 1'b0;
            if (w_issue) begin
                r_addra <= w_addr_sel;
                r_addrb <= w_addr_sel;
                r_dina  <= w_wdata_sel;
            end
        end
    end

    // Completion: one-cycle ack to the owner, capture read data on reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack0 <= w_done & ~r_gnt_id;
            r_ack1 <= w_done & r_gnt_id;
            if (w_done && !r_we_txn) begin
                r_rdata <= doutb;
            end
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign gnt_id = r_gnt_id;
    assign wea    = r_wea;
    assign addra  = r_addra;
    assign dina   = r_dina;
    assign addrb  = r_addrb;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed table vectors plus corner-case sequences.
// Instance 0 uses RD_LAT=1, instances 1 and 2 use RD_LAT=0 and RD_LAT=3.

module tb_ram_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit TIE_WIN = 1'b0;
`else
    localparam bit TIE_WIN = 1'b1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          reqx;
    logic [AW-1:0] xaddr;

    logic [2:0]    req0_v;
    logic [2:0]    ack0_v, ack1_v, busy_v, gnt_v, wea_v;
    logic [AW-1:0] addra_v [3];
    logic [AW-1:0] addrb_v [3];
    logic [DW-1:0] dina_v  [3];
    logic [DW-1:0] rdata_v [3];
    logic [DW-1:0] doutb_v [3];

    assign req0_v = {reqx, reqx, req0};

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [DW-1:0] mem  [64];
        logic [DW-1:0] pipe [4];

        ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .req0   (req0_v[g]),
            .we0    ((g == 0) ? we0 : 1'b0),
            .addr0  ((g == 0) ? addr0 : xaddr),
            .wdata0 ((g == 0) ? wdata0 : 32'd0),
            .req1   ((g == 0) ? req1 : 1'b0),
            .we1    ((g == 0) ? we1 : 1'b0),
            .addr1  ((g == 0) ? addr1 : 6'd0),
            .wdata1 ((g == 0) ? wdata1 : 32'd0),
            .ack0   (ack0_v[g]),
            .ack1   (ack1_v[g]),
            .rdata  (rdata_v[g]),
            .busy   (busy_v[g]),
            .gnt_id (gnt_v[g]),
            .wea    (wea_v[g]),
            .addra  (addra_v[g]),
            .dina   (dina_v[g]),
            .addrb  (addrb_v[g]),
            .doutb  (doutb_v[g])
        );

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[5] = 32'h8;
        end

        always @(posedge clk) begin
            if (wea_v[g]) mem[addra_v[g]] <= dina_v[g];
            pipe[0] <= mem[addrb_v[g]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        if (L == 0) begin : g_comb
            assign doutb_v[g] = mem[addrb_v[g]];
        end else begin : g_reg
            assign doutb_v[g] = pipe[L-1];
        end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        int other;
        int weas;
        if (v.id == 1'b0) begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wd;
        end else begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wd;
        end
        tick();
        chk("issue_busy", busy_v[0], 1);
        chk("issue_gnt", gnt_v[0], v.id);
        chk("issue_addra", addra_v[0], v.addr);
        chk("issue_addrb", addrb_v[0], v.addr);
        chk("issue_wea", wea_v[0], v.we);
        if (v.we) chk("issue_dina", dina_v[0], v.wd);
        n = 1;
        other = 0;
        weas = wea_v[0] ? 1 : 0;
        while (!(v.id ? ack1_v[0] : ack0_v[0]) && n < 12) begin
            tick();
            n++;
            if (wea_v[0]) weas++;
            if (v.id ? ack0_v[0] : ack1_v[0]) other++;
        end
        chk("ack_latency", n, 3);
        chk("txn_rdata", rdata_v[0], v.exp_rd);
        chk("done_busy", busy_v[0], 0);
        chk("other_ack", other, 0);
        chk("wea_pulses", weas, v.we);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk("ack_fall", {ack0_v[0], ack1_v[0]}, 0);
    endtask

    initial begin
        int issues, acks0, acks1, weas, c_first, c_second, c1, c2;
        int gseq [8];
        logic prev_busy;

        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        reqx = 0; xaddr = 0;
        repeat (2) tick();

        chk("rst_ctrl", {ack0_v[0], ack1_v[0], busy_v[0], gnt_v[0], wea_v[0]}, 0);
        chk("rst_rdata", rdata_v[0], 0);
        chk("rst_addra", addra_v[0], 0);
        chk("rst_addrb", addrb_v[0], 0);
        chk("rst_dina", dina_v[0], 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy_v[0], 0);

        tbl[0] = '{1'b0, 1'b0, 6'h05, 32'h0,        32'h8};
        tbl[1] = '{1'b1, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h8};
        tbl[2] = '{1'b0, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b1, 1'b1, 6'h03, 32'h12345678, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b0, 6'h03, 32'h0,        32'h12345678};
        tbl[5] = '{1'b0, 1'b1, 6'h05, 32'hA5A5A5A5, 32'h12345678};
        tbl[6] = '{1'b0, 1'b0, 6'h05, 32'h0,        32'hA5A5A5A5};
        tbl[7] = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF};
        tbl[8] = '{1'b1, 1'b1, 6'h3F, 32'hFFFFFFFF, 32'hDEADBEEF};
        tbl[9] = '{1'b0, 1'b0, 6'h3F, 32'h0,        32'hFFFFFFFF};
        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // req0 write held high through its acks
        req0 = 1; we0 = 1; addr0 = 6'h09; wdata0 = 32'h99;
        issues = 0; acks0 = 0; acks1 = 0; weas = 0;
        c_first = 0; c_second = 0;
        prev_busy = busy_v[0];
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (busy_v[0] && !prev_busy) begin
                issues++;
                if (issues == 1) c_first = c;
                if (issues == 2) c_second = c;
            end
            prev_busy = busy_v[0];
            if (ack0_v[0]) acks0++;
            if (ack1_v[0]) acks1++;
            if (wea_v[0]) weas++;
        end
        req0 = 0; we0 = 0;
        chk("held_issues", issues, 3);
        chk("held_acks0", acks0, 3);
        chk("held_acks1", acks1, 0);
        chk("held_wea", weas, 3);
        chk("held_spacing", c_second - c_first, 4);
        repeat (2) tick();
        chk("held_idle", busy_v[0], 0);

        // simultaneous tie after a grant to requester 0, both drop early
        req0 = 1; we0 = 0; addr0 = 6'h05;
        req1 = 1; we1 = 0; addr1 = 6'h09;
        tick();
        chk("tie_gnt", gnt_v[0], TIE_WIN);
        req0 = 0; req1 = 0;
        acks0 = 0; acks1 = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack0_v[0]) acks0++;
            if (ack1_v[0]) acks1++;
        end
        chk("tie_ack0", acks0, TIE_WIN ? 0 : 1);
        chk("tie_ack1", acks1, TIE_WIN ? 1 : 0);
        chk("tie_rdata", rdata_v[0], TIE_WIN ? 32'h99 : 32'hA5A5A5A5);

        // reset while busy after the write pulse already landed
        req1 = 1; we1 = 1; addr1 = 6'h07; wdata1 = 32'h77;
        tick();
        req1 = 0; we1 = 0;
        tick();
        chk("pre_rst_busy", busy_v[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {ack0_v[0], ack1_v[0], busy_v[0], gnt_v[0], wea_v[0]}, 0);
        chk("abort_rdata", rdata_v[0], 0);
        chk("abort_addr", {addra_v[0], addrb_v[0]}, 0);
        chk("abort_dina", dina_v[0], 0);
        acks0 = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ack0_v[0] || ack1_v[0]) acks0++;
        end
        rst_n = 1'b1;
        tick();
        if (ack0_v[0] || ack1_v[0]) acks0++;
        chk("abort_no_ack", acks0, 0);

        // both held, reads, fresh pointer after reset
        req0 = 1; we0 = 0; addr0 = 6'h05;
        req1 = 1; we1 = 0; addr1 = 6'h07;
        issues = 0; c_first = 0; c_second = 0;
        prev_busy = busy_v[0];
        acks0 = 0; acks1 = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (busy_v[0] && !prev_busy) begin
                if (issues < 8) gseq[issues] = gnt_v[0];
                issues++;
                if (issues == 1) c_first = c;
                if (issues == 2) c_second = c;
            end
            prev_busy = busy_v[0];
            if (ack0_v[0]) begin
                acks0++;
                chk("rr_rdata0", rdata_v[0], 32'hA5A5A5A5);
            end
            if (ack1_v[0]) begin
                acks1++;
                chk("rr_rdata1", rdata_v[0], 32'h77);
            end
        end
        req0 = 0; req1 = 0;
        chk("rr_issues", issues, 5);
        chk("rr_order", {gseq[0][0], gseq[1][0], gseq[2][0], gseq[3][0]}, 4'b0101);
        chk("rr_spacing", c_second - c_first, 3);
        chk("rr_acks", acks0 + acks1, 4);
        repeat (4) tick();
        chk("rr_idle", busy_v[0], 0);

        run_txn('{1'b0, 1'b0, 6'h07, 32'h0, 32'h77});

        // latency variants: one-cycle request pulse
        xaddr = 6'h05;
        reqx = 1;
        tick();
        reqx = 0;
        chk("lat_busy", {busy_v[1], busy_v[2]}, 2'b11);
        c1 = 0; c2 = 0; acks0 = 0;
        for (int n = 2; n <= 8; n++) begin
            tick();
            if (ack0_v[1]) begin c1 = n; acks0++; end
            if (ack0_v[2]) begin c2 = n; acks0++; end
        end
        chk("lat0_ack", c1, 2);
        chk("lat3_ack", c2, 5);
        chk("lat_ack_cnt", acks0, 2);
        chk("lat0_rdata", rdata_v[1], 32'h8);
        chk("lat3_rdata", rdata_v[2], 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
